// File: rtl/cru_intc_pkg.sv
// Shared constants and helpers for the CRU flag register / interrupt controller.
package cru_intc_pkg;

    localparam logic [3:0] BST_INTA = 4'b0101;
    localparam logic [3:0] IC_NONE  = 4'hF;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cru_intc_prio.sv
// Lowest-index-wins priority encoder over N request lines (N <= 16).
module cru_intc_prio #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [3:0]   idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = 4'(i);
        end
    end

endmodule

// File: rtl/cru_intc.sv
// CRU-mapped flag register plus NINT-channel latched interrupt controller.
// Define CRU_INTC_PASSTHRU_EN to OR raw enabled irq_in levels into int_out.
module cru_intc
    import cru_intc_pkg::*;
#(
    parameter logic [15:0]     BASE        = 16'h1EE0,
    parameter int unsigned     NBITS       = 16,
    parameter int unsigned     NINT        = 4,
    parameter int unsigned     FIRST_LEVEL = 1,
    parameter logic [NINT-1:0] EDGE_MASK   = {NINT{1'b1}},
    parameter logic [NINT-1:0] ENABLE_RST  = {NINT{1'b1}}
) (
    input  logic            clk_25mhz,
    input  logic            reset,
    input  logic [15:0]     cab,
    input  logic            cruout,
    input  logic            cruclk,
    input  logic [3:0]      bst,
    input  logic [NINT-1:0] irq_in,
    output logic            sel,
    output logic            cruin,
    output logic            int_out,
    output logic [3:0]      ic,
    output logic [NINT-1:0] pending
);

    localparam int unsigned LB = clog2(NBITS);

    logic            cruclk_q, cruout_q, arm_q, arm_d;
    logic [15:0]     cab_q;
    logic [NBITS-1:0] flag_q, flag_d;
    logic [NINT-1:0] enable_q, enable_d, pending_q, pending_d, irq_q;
    logic [NINT-1:0] set_v, ack_v, act;
    logic            int_q, int_d, prio_valid, chan_w, wr_stb, wr_hit, rd_bit;
    logic [3:0]      ic_q, ic_d, prio_idx;
    logic [LB-1:0]   idx, widx;
    logic            unused_cab;

    assign unused_cab = cab_q[0] ^ cab[0];

    assign sel  = (cab[15:LB+1] == BASE[15:LB+1]);
    assign idx  = cab[LB:1];
    assign widx = cab_q[LB:1];

    always_comb begin
        rd_bit = flag_q[idx];
        for (int k = 0; k < NINT; k++) begin
            if (32'(idx) == FIRST_LEVEL + k) rd_bit = pending_q[k];
        end
        cruin = sel ? rd_bit : 1'b1;
    end

    // arm_q only rises once cruclk has been seen low after reset, so a strobe
    // already high at reset release cannot commit on its falling edge.
    assign arm_d  = arm_q | ~cruclk;
    assign wr_stb = cruclk_q & ~cruclk & arm_q;
    assign wr_hit = wr_stb & (cab_q[15:LB+1] == BASE[15:LB+1]);

    always_comb begin
        flag_d   = flag_q;
        enable_d = enable_q;
        chan_w   = 1'b0;
        if (wr_hit) begin
            for (int k = 0; k < NINT; k++) begin
                if (32'(widx) == FIRST_LEVEL + k) begin
                    enable_d[k] = cruout_q;
                    chan_w      = 1'b1;
                end
            end
            if (!chan_w) flag_d[widx] = cruout_q;
        end
    end

    always_comb begin
        set_v     = '0;
        ack_v     = '0;
        pending_d = pending_q;
        for (int k = 0; k < NINT; k++) begin
            set_v[k] = EDGE_MASK[k] ? (irq_in[k] & ~irq_q[k]) : irq_in[k];
            ack_v[k] = (bst == BST_INTA) && (32'(cab[5:2]) == FIRST_LEVEL + k);
            // A set in the same cycle as its acknowledge wins.
            pending_d[k] = set_v[k] | (pending_q[k] & ~ack_v[k]);
        end
    end

    assign act = pending_q & enable_q;

    cru_intc_prio #(
        .N (NINT)
    ) u_prio (
        .req_i   (act),
        .valid_o (prio_valid),
        .idx_o   (prio_idx)
    );

    assign int_d = |act;
    assign ic_d  = prio_valid ? (4'(FIRST_LEVEL) + prio_idx) : IC_NONE;

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            cruclk_q  <= 1'b0;
            cruout_q  <= 1'b0;
            cab_q     <= '0;
            arm_q     <= 1'b0;
            flag_q    <= '0;
            enable_q  <= ENABLE_RST;
            pending_q <= '0;
            irq_q     <= '0;
            int_q     <= 1'b0;
            ic_q      <= IC_NONE;
        end else begin
            cruclk_q  <= cruclk;
            cruout_q  <= cruout;
            cab_q     <= cab;
            arm_q     <= arm_d;
            flag_q    <= flag_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
            irq_q     <= irq_in;
            int_q     <= int_d;
            ic_q      <= ic_d;
        end
    end

`ifdef CRU_INTC_PASSTHRU_EN
    assign int_out = int_q | (|(irq_in & enable_q));
`else
    assign int_out = int_q;
`endif
    assign ic      = ic_q;
    assign pending = pending_q;

endmodule
